// File: rtl/rf_pkg.sv
// Shared defaults and the byte-lane helper for the multiport register file.
package rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NRD      = 2;
  localparam int RF_ZERO_REG = 1;
  localparam int RF_BYPASS   = 1;

  function automatic int rf_lanes(input int data_w);
    return data_w / 8;
  endfunction

  localparam int RF_LANES = rf_lanes(RF_DATA_W);
endpackage

// File: rtl/rf_byte_merge.sv
// Per-lane merge of two write ports onto an old value; port 1 wins a shared lane.
// Purely combinational, no backpressure.
module rf_byte_merge
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic [DATA_W-1:0]           old_val,
  input  logic                        en0,
  input  logic [rf_lanes(DATA_W)-1:0] be0,
  input  logic [DATA_W-1:0]           wd0,
  input  logic                        en1,
  input  logic [rf_lanes(DATA_W)-1:0] be1,
  input  logic [DATA_W-1:0]           wd1,
  output logic [DATA_W-1:0]           merged
);
  localparam int LANES = rf_lanes(DATA_W);

  always_comb begin
    merged = old_val;
    for (int i = 0; i < LANES; i++) begin
      if (en1 && be1[i])
        merged[i*8 +: 8] = wd1[i*8 +: 8];
      else if (en0 && be0[i])
        merged[i*8 +: 8] = wd0[i*8 +: 8];
    end
  end
endmodule

// File: rtl/rf_multiport.sv
// Two-write, NRD-read register file with byte enables, optional write bypass and a busy scoreboard.
// Reads and rbusy are combinational (latency 0); writes/issues land at the clock edge; no backpressure.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = RF_NRD,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int BYPASS   = RF_BYPASS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we0,
  input  logic                        we1,
  input  logic [ADDR_W-1:0]           wa0,
  input  logic [ADDR_W-1:0]           wa1,
  input  logic [DATA_W-1:0]           wd0,
  input  logic [DATA_W-1:0]           wd1,
  input  logic [rf_lanes(DATA_W)-1:0] be0,
  input  logic [rf_lanes(DATA_W)-1:0] be1,
  input  logic [NRD*ADDR_W-1:0]       ra,
  output logic [NRD*DATA_W-1:0]       rd,
  output logic [NRD-1:0]              rbusy,
  input  logic                        iss_v,
  input  logic [ADDR_W-1:0]           iss_a,
  output logic [ADDR_W:0]             busy_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] mem_nxt [DEPTH];
  logic [DEPTH-1:0]  busy, busy_nxt;
  logic              we0_e, we1_e, iss_e;
  logic              inc, dec0, dec1;

  // Address 0 is masked out here so it can never be written or marked busy.
  assign we0_e = we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign we1_e = we1 && !(ZERO_REG != 0 && wa1 == '0);
  assign iss_e = iss_v && !(ZERO_REG != 0 && iss_a == '0);

  for (genvar r = 0; r < DEPTH; r++) begin : g_wr
    rf_byte_merge #(.DATA_W(DATA_W)) u_merge (
      .old_val (mem[r]),
      .en0     (we0_e && wa0 == ADDR_W'(r)),
      .be0     (be0),
      .wd0     (wd0),
      .en1     (we1_e && wa1 == ADDR_W'(r)),
      .be1     (be1),
      .wd1     (wd1),
      .merged  (mem_nxt[r])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = ra[k*ADDR_W +: ADDR_W];
    // Bypass is gated by reset so that asserting reset zeroes rd immediately.
    rf_byte_merge #(.DATA_W(DATA_W)) u_byp (
      .old_val (mem[a]),
      .en0     (BYPASS != 0 && reset && we0_e && wa0 == a),
      .be0     (be0),
      .wd0     (wd0),
      .en1     (BYPASS != 0 && reset && we1_e && wa1 == a),
      .be1     (be1),
      .wd1     (wd1),
      .merged  (rd[k*DATA_W +: DATA_W])
    );
    assign rbusy[k] = busy[a];
  end

  always_comb begin
    busy_nxt = busy;
    if (we0_e && |be0) busy_nxt[wa0] = 1'b0;
    if (we1_e && |be1) busy_nxt[wa1] = 1'b0;
    if (iss_e)         busy_nxt[iss_a] = 1'b1;
  end

  // Incremental count: a clear only counts when the target was busy and not re-issued,
  // and two ports clearing one address count once.
  assign inc  = iss_e && !busy[iss_a];
  assign dec0 = we0_e && |be0 && busy[wa0] && !(iss_e && iss_a == wa0);
  assign dec1 = we1_e && |be1 && busy[wa1] && !(iss_e && iss_a == wa1) && !(dec0 && wa0 == wa1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec0}
                           - {{ADDR_W{1'b0}}, dec1};
    end
  end
endmodule

// File: tb/tb_rf_multiport.sv
// Directed vector bench for rf_multiport at default parameters.
module tb_rf_multiport;
  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, iss_v;
  logic [4:0]  wa0, wa1, iss_a;
  logic [31:0] wd0, wd1;
  logic [3:0]  be0, be1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic [5:0]  busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  rf_multiport dut (
    .clk(clk), .reset(reset),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
    .wd0(wd0), .wd1(wd1), .be0(be0), .be1(be1),
    .ra(ra), .rd(rd), .rbusy(rbusy),
    .iss_v(iss_v), .iss_a(iss_a), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we0;  logic [4:0] wa0; logic [31:0] wd0; logic [3:0] be0;
    logic        we1;  logic [4:0] wa1; logic [31:0] wd1; logic [3:0] be1;
    logic        iss_v; logic [4:0] iss_a;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_rbusy;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic w0, input logic [4:0] a0, input logic [31:0] d0, input logic [3:0] b0,
    input logic w1, input logic [4:0] a1, input logic [31:0] d1, input logic [3:0] b1,
    input logic iv, input logic [4:0] ia, input logic [4:0] r0, input logic [4:0] r1,
    input logic [31:0] x0, input logic [31:0] x1, input logic [1:0] xb, input logic [5:0] xc);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0; v.be0 = b0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1; v.be1 = b1;
    v.iss_v = iv; v.iss_a = ia; v.ra0 = r0; v.ra1 = r1;
    v.e_rd0 = x0; v.e_rd1 = x1; v.e_rbusy = xb; v.e_cnt = xc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    we0 = 0; wa0 = 0; wd0 = 0; be0 = 0;
    we1 = 0; wa1 = 0; wd1 = 0; be1 = 0;
    iss_v = 0; iss_a = 0;
  endtask

  task automatic check_all(input string tag, input logic [31:0] x0, input logic [31:0] x1,
                           input logic [1:0] xb, input logic [5:0] xc);
    chk({tag, ".rd0"},   rd[31:0],  x0);
    chk({tag, ".rd1"},   rd[63:32], x1);
    chk({tag, ".rbusy"}, {30'd0, rbusy}, {30'd0, xb});
    chk({tag, ".cnt"},   {26'd0, busy_cnt}, {26'd0, xc});
  endtask

  initial begin
    //                w0 wa0  wd0           be0   w1 wa1  wd1           be1   iv ia    ra0    ra1    rd0           rd1           rb     cnt
    vecs.push_back(mk(0, 19, 32'd121,      4'hF, 0, 0,  32'd0,        4'h0, 0, 0,    5'd19, 5'd0,  32'd0,        32'd0,        2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd19, 5'd0,  32'd0,        32'd0,        2'b00, 6'd0));
    vecs.push_back(mk(1, 13, 32'd45,       4'hF, 0, 0,  32'd0,        4'h0, 0, 0,    5'd19, 5'd13, 32'd0,        32'd45,       2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd19, 5'd13, 32'd0,        32'd45,       2'b00, 6'd0));
    vecs.push_back(mk(1, 7,  32'h11223344, 4'hF, 1, 7,  32'hAABBCCDD, 4'h3, 0, 0,    5'd7,  5'd13, 32'h1122CCDD, 32'd45,       2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd7,  5'd13, 32'h1122CCDD, 32'd45,       2'b00, 6'd0));
    vecs.push_back(mk(1, 0,  32'hFFFFFFFF, 4'hF, 0, 0,  32'd0,        4'h0, 1, 0,    5'd0,  5'd7,  32'd0,        32'h1122CCDD, 2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd0,  5'd7,  32'd0,        32'h1122CCDD, 2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 1, 3,    5'd3,  5'd5,  32'd0,        32'd0,        2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 1, 5,    5'd3,  5'd5,  32'd0,        32'd0,        2'b01, 6'd1));
    vecs.push_back(mk(1, 3,  32'h000000A5, 4'h1, 0, 0,  32'd0,        4'h0, 1, 3,    5'd3,  5'd5,  32'h000000A5, 32'd0,        2'b11, 6'd2));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd3,  5'd5,  32'h000000A5, 32'd0,        2'b11, 6'd2));
    vecs.push_back(mk(1, 3,  32'h00000100, 4'h2, 1, 5,  32'h00000055, 4'h1, 0, 0,    5'd3,  5'd5,  32'h000001A5, 32'h00000055, 2'b11, 6'd2));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd3,  5'd5,  32'h000001A5, 32'h00000055, 2'b00, 6'd0));
    vecs.push_back(mk(1, 13, 32'hDEADBEEF, 4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd7,  5'd13, 32'h1122CCDD, 32'd45,       2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 1, 9,    5'd9,  5'd13, 32'd0,        32'd45,       2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 1, 9,  32'hFFFFFFFF, 4'h0, 0, 0,    5'd9,  5'd13, 32'd0,        32'd45,       2'b01, 6'd1));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd9,  5'd13, 32'd0,        32'd45,       2'b01, 6'd1));
    vecs.push_back(mk(1, 9,  32'h00000001, 4'h1, 1, 9,  32'h00000200, 4'h2, 0, 0,    5'd9,  5'd13, 32'h00000201, 32'd45,       2'b01, 6'd1));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd9,  5'd13, 32'h00000201, 32'd45,       2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 1, 9,    5'd9,  5'd13, 32'h00000201, 32'd45,       2'b00, 6'd0));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 1, 9,    5'd9,  5'd13, 32'h00000201, 32'd45,       2'b01, 6'd1));
    vecs.push_back(mk(0, 0,  32'd0,        4'h0, 0, 0,  32'd0,        4'h0, 0, 0,    5'd9,  5'd13, 32'h00000201, 32'd45,       2'b01, 6'd1));

    reset = 1'b0;
    idle();
    ra = {5'd13, 5'd7};
    #1;
    check_all("reset", 32'd0, 32'd0, 2'b00, 6'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0; be0 = vecs[i].be0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1; be1 = vecs[i].be1;
      iss_v = vecs[i].iss_v; iss_a = vecs[i].iss_a;
      ra = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_rbusy, vecs[i].e_cnt);
    end

    // Reach busy_cnt=2 (9 is still busy), then assert reset in the middle of a write cycle.
    @(negedge clk);
    idle();
    iss_v = 1; iss_a = 3; ra = {5'd13, 5'd9};
    @(negedge clk);
    idle();
    we0 = 1; wa0 = 13; wd0 = 32'h00000077; be0 = 4'hF;
    ra = {5'd13, 5'd9};
    #1;
    check_all("pre_rst", 32'h00000201, 32'h00000077, 2'b01, 6'd2);
    #1 reset = 1'b0;
    #1;
    check_all("async_rst", 32'd0, 32'd0, 2'b00, 6'd0);

    // The write held across an edge during reset must be discarded.
    @(negedge clk);
    reset = 1'b1;
    idle();
    ra = {5'd13, 5'd9};
    #1;
    check_all("post_rst", 32'd0, 32'd0, 2'b00, 6'd0);

    @(negedge clk);
    we0 = 1; wa0 = 13; wd0 = 32'h00000099; be0 = 4'hF;
    @(negedge clk);
    idle();
    ra = {5'd13, 5'd9};
    #1;
    check_all("first_wr", 32'd0, 32'h00000099, 2'b00, 6'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_multiport.md
RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, range 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1, meaning a same-cycle write is forwarded to reads.
REQ-006 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port we0 / we1  in  1 each  write enable for write ports 0 and 1.
REQ-009 SHALL have port wa0 / wa1  in  ADDR_W each  write addresses.
REQ-010 SHALL have port wd0 / wd1  in  DATA_W each  write data.
REQ-011 SHALL have port be0 / be1  in  DATA_W/8 each  byte enables; bit i covers byte i.
REQ-012 SHALL have port ra  in  NRD*ADDR_W  packed read addresses; port k at slice k.
REQ-013 SHALL have port rd  out  NRD*DATA_W  packed read data.
REQ-014 SHALL have port rbusy  out  NRD  scoreboard busy flag of each read address.
REQ-015 SHALL have port iss_v  in  1  issue strobe: mark register iss_a as pending.
REQ-016 SHALL have port iss_a  in  ADDR_W  register to mark pending.
REQ-017 SHALL have port busy_cnt  out  ADDR_W+1  count of pending registers.

Function
REQ-018 SHALL update a byte lane of register wa0 from wd0 at the clock edge only when we0=1 and that lane's be0 bit is 1; the same rule SHALL apply to port 1.
REQ-019 SHALL, when both ports write the same address, take each lane from port 1 if be1 is set, else from port 0 if be0 is set, else keep the old value.
REQ-020 SHALL drive rd slice k combinationally from register ra[k]; read latency 0.
REQ-021 SHALL, with BYPASS=1, return the merged post-write value (per REQ-019) when ra[k] matches an enabled write address in the same cycle; with BYPASS=0, return the pre-edge value.
REQ-022 SHALL, with ZERO_REG=1, ignore writes and issues to address 0, read 0 from it, and report it never busy.
REQ-023 SHALL keep one busy bit per register; iss_v=1 sets busy[iss_a] at the edge.
REQ-024 SHALL clear busy[a] at the edge when an enabled write targets a with any byte enable set, regardless of which port writes.
REQ-025 SHALL, when an issue and a clearing write to the same address occur in one cycle, leave busy set (issue wins).
REQ-026 SHALL drive rbusy[k] = busy[ra[k]] combinationally, without bypass.
REQ-027 SHALL maintain busy_cnt as a registered counter that changes by +1, 0, -1 or -2 per cycle and always equals the population count of busy; it SHALL never wrap (maximum DEPTH).
REQ-028 SHALL treat issuing an already-busy register as no count change.

Reset
REQ-029 SHALL, while reset=0, asynchronously clear all registers, all busy bits and busy_cnt to 0, so rd=0 and rbusy=0.
REQ-030 SHALL discard any write or issue coincident with reset assertion; the first update SHALL occur at the first rising edge with reset=1.

Structure
REQ-031 SHALL take default parameter values and a byte-lane-count constant from shared package rf_pkg.
REQ-032 SHALL instantiate one sub-module, rf_byte_merge, which applies the two write ports' enables and byte enables to an old value (used by both the write path and the bypass path).
REQ-033 SHALL contain no latches; the storage array SHALL be a DEPTH x DATA_W register array.

Verification
REQ-034 SHALL check: reset, we0=0 wa0=19 wd0=121 for one cycle, then ra[0]=19 -> rd slice 0 = 0.
REQ-035 SHALL check: we0=1 wa0=13 wd0=45 be0=all-ones, then ra[1]=13 -> 45; with BYPASS=1, 45 appears in the write cycle itself.
REQ-036 SHALL check: we0/we1 both to address 7, wd0=0x11223344 be0=0xF, wd1=0xAABBCCDD be1=0x3 -> 0x1122CCDD.
REQ-037 SHALL check: write 0xFFFFFFFF to address 0 with ZERO_REG=1 -> reads 0; iss_a=0 -> busy_cnt stays 0.
REQ-038 SHALL check: issue 3, then 5 -> busy_cnt=2; write 3 plus issue 3 in the same cycle -> rbusy for 3 =1 and busy_cnt=2; dual write to 3 and 5 -> busy_cnt=0.
REQ-039 SHALL check: reset asserted mid-write with busy_cnt=2 -> all outputs 0 immediately, without waiting for a clock edge.
